// File: rtl/stream_slice_sched.sv
// -----------------------------------------------------------------------------
// stream_slice_sched
//
// Packet-level sequencer for the slice-reorder datapath. It accepts one
// per-packet config (direction, slice size, word count). It then passes that
// many words from a valid/ready source through the slice-reorder transform into
// a single output register, marks the final word with out_last and pulses
// pkt_done once that word has left.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_valid  : config offer
//   cfg_ready  : high while idle; config taken on cfg_valid & cfg_ready
//   cfg_dir    : 0 = pass-through, 1 = left stream {<< s {word}}
//   cfg_slice  : slice size s in bits (0 behaves as 1)
//   cfg_len    : words in the packet (0 means 2**LENW)
//   in_valid   : input word valid
//   in_ready   : input word taken on in_valid & in_ready
//   in_data    : input word
//   out_valid  : output register holds a word
//   out_ready  : sink takes the word on out_valid & out_ready
//   out_data   : reordered word
//   out_last   : out_data is the final word of the packet
//   busy       : a packet is in progress
//   pkt_done   : one-cycle pulse the cycle after the last word left
// -----------------------------------------------------------------------------
module stream_slice_sched #(
    parameter int DW   = 32,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            cfg_dir,
    input  logic [5:0]      cfg_slice,
    input  logic [LENW-1:0] cfg_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            busy,
    output logic            pkt_done
);

    localparam int IW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [5:0]      slice_q, slice_d;
    logic [LENW:0]   rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            pkt_done_q, pkt_done_d;

    logic            cfg_fire;
    logic            in_fire;
    logic            out_fire;
    logic            rem_is_one;
    logic [DW-1:0]   rev_data;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    assign cfg_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    // The output register can take a new word in the same cycle it empties.
    assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign rem_is_one = (rem_q == {{LENW{1'b0}}, 1'b1});

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign pkt_done   = pkt_done_q;

    // -------------------------------------------------------------------------
    // Slice reorder {<< s {in_data}}.
    // Walk the input bits from the LSB. The walk tracks the base of the current
    // block; a block ends when it holds s bits or reaches the top of the word.
    // The block occupying input bits [base, top) lands at output bits
    // [DW-top, DW-base), so block 0 sits at the MSB end and a short top block
    // ends up in the low bits. For s >= DW there is a single block, so the
    // walk degenerates to identity; it is skipped in that case anyway.
    // -------------------------------------------------------------------------
    always_comb begin
        int             s;
        int             base;
        int             top;
        logic [IW-1:0]  dest_idx;
        rev_data = in_data;
        s        = int'(slice_q);
        base     = 0;
        top      = 0;
        dest_idx = '0;
        if (dir_q && (s < DW) && (s > 0)) begin
            for (int i = 0; i < DW; i++) begin
                if ((i - base) == s) begin
                    base = base + s;
                end
                top = base + s;
                if (top > DW) begin
                    top = DW;
                end
                dest_idx = IW'(DW - top + i - base);
                rev_data[dest_idx] = in_data[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The last word needs one cycle in the output register, so it
                // cannot leave in the cycle it is accepted; DRAIN is always
                // visited for at least one cycle.
                if (in_fire && rem_is_one) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Config latch, word counter and output register
    // -------------------------------------------------------------------------
    always_comb begin
        dir_d       = dir_q;
        slice_d     = slice_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        pkt_done_d  = out_fire && out_last_q;

        if (cfg_fire) begin
            dir_d   = cfg_dir;
            slice_d = (cfg_slice == 6'd0) ? 6'd1 : cfg_slice;
            // A zero length field encodes the full 2**LENW words.
            rem_d   = (cfg_len == '0) ? {1'b1, {LENW{1'b0}}} : {1'b0, cfg_len};
        end

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = rev_data;
            out_last_d  = rem_is_one;
            rem_d       = rem_q - {{LENW{1'b0}}, 1'b1};
        end else if (out_fire) begin
            // Data is left in place; only the qualifiers drop.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= 1'b0;
            slice_q     <= 6'd0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            slice_q     <= slice_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

endmodule
